// File: rtl/sequential_multiplier.sv
// Unsigned shift-and-add multiplier: one multiplier bit per clock, WIDTH cycles from accepted start to done.
// No backpressure: start is accepted in IDLE or DONE, ignored while BUSY; the product holds until the next completion.
module sequential_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product,
   output logic               done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_sum;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               load;
   logic               step;
   logic               last;

   assign last    = (cnt == CW'(WIDTH - 1));
   assign acc_sum = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = BUSY;
         BUSY:    if (last)  state_nxt = DONE;
         DONE:    if (start) state_nxt = BUSY;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load = 1'b0;
      step = 1'b0;
      done = 1'b0;
      case (state)
         IDLE:    load = start;
         BUSY:    step = 1'b1;
         DONE:    begin
            load = start;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // The final partial product is folded in on the last BUSY edge, so product
   // is written with acc_sum rather than the registered accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (step) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (last) product <= acc_sum;
      end
   end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed bench for sequential_multiplier: a cycle-level reference model plus hand-computed literal checks.
module tb_sequential_multiplier;

   localparam int W  = 8;
   localparam int PW = 2 * W;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [PW-1:0] product;
   logic          done;

   int n_vec  = 0;
   int n_miss = 0;
   bit chk_en = 0;

   sequential_multiplier #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .product (product),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: an accepted start schedules the true product a*b to
   // appear exactly W edges later; nothing else changes the visible result.
   logic [PW-1:0] m_product = '0;
   logic [PW-1:0] m_pending = '0;
   logic          m_done    = 1'b0;
   int            m_remain  = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_product <= '0;
         m_pending <= '0;
         m_done    <= 1'b0;
         m_remain  <= 0;
      end else if (m_remain != 0) begin
         m_remain <= m_remain - 1;
         if (m_remain == 1) begin
            m_product <= m_pending;
            m_done    <= 1'b1;
         end
      end else if (start) begin
         m_pending <= PW'(a) * PW'(b);
         m_remain  <= W;
         m_done    <= 1'b0;
      end
   end

   task automatic check(input string name, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_product", longint'(product), longint'(m_product));
         check("model_done", longint'(done), longint'(m_done));
      end
   end

   // All tasks enter and leave 1 time unit after a rising edge.
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int n0, output int n);
      n = n0;
      while (!done && n < 4 * W) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input longint exp);
      logic [PW-1:0] held;
      int            lat;
      held = product;
      start_op(av, bv);
      check({name, "_done_clr"}, longint'(done), 0);
      check({name, "_held"}, longint'(product), longint'(held));
      wait_done(0, lat);
      check({name, "_latency"}, lat, W);
      check({name, "_product"}, longint'(product), exp);
      check({name, "_model_pin"}, longint'(m_product), exp);
      @(posedge clk);
      #1;
      check({name, "_hold_done"}, longint'(done), 1);
      check({name, "_hold_prod"}, longint'(product), exp);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      check("reset_product", longint'(product), 0);
      check("reset_done", longint'(done), 0);

      run_op("mul_5x3", 8'd5, 8'd3, 15);
      run_op("mul_15x10", 8'd15, 8'd10, 150);
      run_op("mul_255x255", 8'd255, 8'd255, 65025);
      run_op("mul_10x0", 8'd10, 8'd0, 0);

      // start raised mid-operation with new operands must be ignored
      start_op(8'd7, 8'd9);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      a     = 8'd2;
      b     = 8'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_start_done", longint'(done), 0);
      wait_done(4, lat);
      check("busy_start_latency", lat, W);
      check("busy_start_product", longint'(product), 63);

      // asynchronous abort part-way through an operation
      @(posedge clk);
      #1;
      start_op(8'd200, 8'd100);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_product", longint'(product), 0);
      check("abort_done", longint'(done), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("abort_still_zero", longint'(product), 0);
      run_op("mul_12x12", 8'd12, 8'd12, 144);

      // start held high: one-cycle done pulse every W+1 cycles
      a     = 8'd3;
      b     = 8'd4;
      start = 1'b1;
      for (int i = 1; i <= 3 * (W + 1); i++) begin
         @(posedge clk);
         #1;
         check("stream_done", longint'(done), longint'(i % (W + 1) == 0));
         if (i % (W + 1) == 0) check("stream_product", longint'(product), 12);
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/sequential_multiplier.md
Name: sequential_multiplier

Overview:
- Unsigned shift-and-add multiplier; consumes one multiplier bit per clock.
- Used as a compact, area-cheap multiply resource where latency of WIDTH cycles is acceptable.
- Start/done handshake; the product is held stable in a register until the next operation completes.

Parameters:
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- start  input  1  request to begin a multiply; sampled on rising clk
- a  input  WIDTH  multiplicand, unsigned; sampled only when start is accepted
- b  input  WIDTH  multiplier, unsigned; sampled only when start is accepted
- product  output  2*WIDTH  registered result a*b of the last completed operation
- done  output  1  level flag: high while product holds a freshly completed result

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, product=0, done=0, internal accumulator/counter/operand registers=0. Reset mid-operation aborts it; no result is produced.
- States: IDLE, BUSY, DONE.
- IDLE: start=1 at a rising edge (edge E0) is accepted:
  - latch a into the multiplicand register, zero-extended to 2*WIDTH;
  - latch b into the multiplier shift register;
  - clear the accumulator and the bit counter;
  - go to BUSY.
- BUSY, each edge:
  - if multiplier LSB=1, accumulator += shifted multiplicand;
  - multiplicand shifts left 1; multiplier shifts right 1; counter increments.
  - After exactly WIDTH BUSY edges (edge E0+WIDTH), load the final sum into product, set done=1, go to DONE.
- Latency: done rises at edge E0+WIDTH; WIDTH=8 gives 8 cycles after the start edge.
- No early termination. Latency is always WIDTH cycles, independent of operand values (zero operands included).
- DONE:
  - done stays 1 and product stays constant until a new start is accepted.
  - start=1 in DONE is accepted exactly as in IDLE: done clears on that same edge, operands are latched, go to BUSY.
- start while BUSY is ignored; a and b changes during BUSY have no effect.
- start held high continuously: a new operation is accepted on the edge after each completion, so done pulses high for 1 cycle per result.
- product is not updated during BUSY; it keeps the previous result (0 after reset) until completion.
- Arithmetic: unsigned, full 2*WIDTH result, no overflow possible. Max case (2^WIDTH-1)^2 fits.
- done=0 in IDLE and BUSY.
- Accumulator width 2*WIDTH; counter width clog2(WIDTH+1).

Test Plan:
- Reset 2 cycles then release -> product=0, done=0. Then a=5, b=3, start pulsed 1 cycle -> done rises 8 cycles after start edge, product=15, held until next start.
- From DONE, a=15, b=10, start pulse -> done falls on start edge, rises 8 cycles later, product=150. Between those edges product stays 15.
- a=255, b=255 -> product=65025; a=10, b=0 -> product=0, latency still 8 cycles.
- Start accepted with a=7, b=9; 3 cycles later drive start=1 with a=2, b=2 -> ignored, product=63 at the normal done time.
- Start accepted with a=200, b=100; assert rst_n=0 at cycle 4 -> product=0, done=0 immediately (asynchronous). After release, start with a=12, b=12 -> product=144.
- start held high with a=3, b=4 -> done is 1 for one cycle every 9 cycles, product=12 each time.
